comparator_stats_4_bit: RTL and testbench
=========================================

Name: comparator_stats_4_bit

Overview:
Downstream statistics stage for the 4-bit magnitude comparator. Each cycle it consumes the comparator's one-hot result flags (a_eq_b, a_gt_b, a_lt_b), qualified by in_valid. It keeps saturating per-outcome counters and a run-length of identical consecutive outcomes, and raises an alert when a run reaches a programmable limit. It also flags illegal (non-one-hot) flag combinations.

Parameters:
CNT_W, 8, width of eq/gt/lt/total counters (saturating)
RUN_W, 4, width of run-length counter (saturating)
RUN_LIMIT, 4, run length at which alert asserts; legal range 1..2^RUN_W-1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous soft clear; same effect as rst
in_valid  input  1  flags are sampled this cycle
a_eq_b  input  1  comparator equal flag
a_gt_b  input  1  comparator greater-than flag
a_lt_b  input  1  comparator less-than flag
eq_count  output  CNT_W  number of legal eq samples
gt_count  output  CNT_W  number of legal gt samples
lt_count  output  CNT_W  number of legal lt samples
total_count  output  CNT_W  number of legal samples
last_result  output  2  00 none, 01 eq, 10 gt, 11 lt
run_len  output  RUN_W  consecutive identical legal results, including the current one
alert  output  1  run_len >= RUN_LIMIT (FSM in ALERT)
err  output  1  sticky; an illegal flag combination was seen

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. Both are fixed.
- Reset and clear, sampled at the clk edge: all counters 0, last_result 00, run_len 0, alert 0, err 0, FSM to IDLE.
- Priority: rst > clear > in_valid. A sample presented in the same cycle as clear is dropped.
- All outputs are registered. A sample at edge N is reflected on the outputs after edge N, so latency is 1 cycle. There is no backpressure; a sample is accepted every valid cycle.
- Legal sample: in_valid=1 and exactly one flag high. Illegal sample: in_valid=1 and zero, two or three flags high.
- On an illegal sample: err <= 1 (sticky until rst/clear). Counters, run_len, last_result and FSM state are unchanged.
- When in_valid=0, nothing changes.
- Legal sample, counters: the matching counter +1 and total_count +1. Each counter saturates independently at 2^CNT_W-1 and never wraps.
- Legal sample, run length:
  - If the code equals last_result, run_len +1, saturating at 2^RUN_W-1.
  - Otherwise run_len <= 1 and last_result <= new code.
- FSM (state encoding internal; alert is the registered ALERT indication):
  - IDLE: no legal sample since reset/clear. Any legal sample goes to TRACK, or directly to ALERT if RUN_LIMIT=1.
  - TRACK: go to ALERT when the updated run_len >= RUN_LIMIT.
  - ALERT: stay while the same result repeats. A different legal result sets run_len=1 and returns to TRACK, or stays in ALERT if RUN_LIMIT=1. Illegal samples do not leave ALERT.
- alert = 1 exactly while in ALERT, and is consistent with run_len on every cycle.
- Saturated run_len keeps alert asserted.
- Reset or clear during ALERT deasserts alert on the next cycle.

Test Plan:
- Reset: after rst for 2 cycles, all counters 0, last_result 00, run_len 0, alert 0, err 0. Hold in_valid=0 for 5 cycles -> outputs unchanged.
- Mixed stream, one per cycle: eq, gt, lt, gt (A/B pairs 1010/1010, 1011/1010, 0000/1111, 1111/0000) -> eq_count 1, gt_count 2, lt_count 1, total_count 4, last_result 10, run_len 1, alert 0. Each update is visible one cycle after its sample.
- Alert with RUN_LIMIT=4:
  - 4 consecutive eq samples -> alert rises the cycle after the 4th sample; run_len 4.
  - 5th eq -> run_len 5, alert stays 1.
  - Then one lt -> run_len 1, last_result 11, alert 0.
- Illegal combination:
  - in_valid=1 with eq=1 and gt=1 -> err 1; counters and run_len unchanged.
  - In_valid=1 with all flags 0 -> err stays 1.
  - clear -> err 0 and all state zeroed.
- Saturation with CNT_W=3, RUN_W=3:
  - 10 consecutive gt samples -> gt_count 7, total_count 7, run_len 7, alert 1.
  - Counters never wrap to 0.
- Priority: assert clear together with a legal lt sample while in ALERT -> next cycle all counters 0, alert 0, last_result 00; the lt sample is not counted.

Source files
------------

// File: rtl/comparator_stats_4_bit_if.sv
// Bundle between the 4-bit magnitude comparator and its statistics stage.
// Carries the qualified one-hot flags in, and the registered statistics and FSM state out.
interface comparator_stats_4_bit_if #(
   parameter int CNT_W = 8,
   parameter int RUN_W = 4
);
   logic             clear;
   logic             in_valid;
   logic             a_eq_b;
   logic             a_gt_b;
   logic             a_lt_b;
   logic [CNT_W-1:0] eq_count;
   logic [CNT_W-1:0] gt_count;
   logic [CNT_W-1:0] lt_count;
   logic [CNT_W-1:0] total_count;
   logic [1:0]       last_result;
   logic [RUN_W-1:0] run_len;
   logic             alert;
   logic             err;
   logic [1:0]       fsm_state;

   // Handshake: in_valid qualifies the three flags for exactly the cycle it is high.
   // There is no ready; the stage accepts one sample on every valid cycle.
   modport slave (
      input  clear, in_valid, a_eq_b, a_gt_b, a_lt_b,
      output eq_count, gt_count, lt_count, total_count,
             last_result, run_len, alert, err, fsm_state
   );

   modport master (
      output clear, in_valid, a_eq_b, a_gt_b, a_lt_b,
      input  eq_count, gt_count, lt_count, total_count,
             last_result, run_len, alert, err, fsm_state
   );
endinterface

// File: rtl/comparator_stats_4_bit.sv
// Statistics stage for the 4-bit comparator: saturating outcome counters, run-length
// tracking with a run-limit alert FSM, and a sticky flag for non-one-hot inputs.
module comparator_stats_4_bit #(
   parameter int CNT_W     = 8,
   parameter int RUN_W     = 4,
   parameter int RUN_LIMIT = 4
) (
   input logic                    clk,
   input logic                    rst,
   comparator_stats_4_bit_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] TRACK = 2'b01;
   localparam logic [1:0] ALERT = 2'b10;

   localparam logic [1:0] CODE_EQ = 2'b01;
   localparam logic [1:0] CODE_GT = 2'b10;
   localparam logic [1:0] CODE_LT = 2'b11;

   localparam logic [RUN_W-1:0] LIMIT   = RUN_W'(RUN_LIMIT);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic [CNT_W-1:0] eq_q;
   logic [CNT_W-1:0] gt_q;
   logic [CNT_W-1:0] lt_q;
   logic [CNT_W-1:0] total_q;
   logic [1:0]       last_q;
   logic [RUN_W-1:0] run_q;
   logic             err_q;
   logic [1:0]       state_q;
   logic [1:0]       state_d;

   logic [2:0]       flags;
   logic             one_hot;
   logic             legal;
   logic             illegal;
   logic [1:0]       code;
   logic             same;
   logic [RUN_W-1:0] run_d;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign flags = {bus.a_eq_b, bus.a_gt_b, bus.a_lt_b};

   always_comb begin
      one_hot = 1'b0;
      code    = CODE_LT;
      case (flags)
         3'b100: begin one_hot = 1'b1; code = CODE_EQ; end
         3'b010: begin one_hot = 1'b1; code = CODE_GT; end
         3'b001: begin one_hot = 1'b1; code = CODE_LT; end
         default: begin one_hot = 1'b0; code = CODE_LT; end
      endcase
   end

   assign legal   = bus.in_valid & one_hot;
   assign illegal = bus.in_valid & ~one_hot;

   // last_q is 00 until the first legal sample, so the first sample never extends a run.
   assign same  = (code == last_q);
   assign run_d = same ? ((&run_q) ? run_q : run_q + 1'b1) : RUN_ONE;

   always_comb begin
      state_d = state_q;
      if (legal) begin
         case (state_q)
            IDLE:    state_d = (run_d >= LIMIT) ? ALERT : TRACK;
            TRACK:   if (run_d >= LIMIT) state_d = ALERT;
            ALERT:   if (!same) state_d = (run_d >= LIMIT) ? ALERT : TRACK;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         eq_q    <= '0;
         gt_q    <= '0;
         lt_q    <= '0;
         total_q <= '0;
         last_q  <= 2'b00;
         run_q   <= '0;
         err_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         if (illegal) err_q <= 1'b1;
         if (legal) begin
            case (code)
               CODE_EQ: eq_q <= sat_cnt(eq_q);
               CODE_GT: gt_q <= sat_cnt(gt_q);
               default: lt_q <= sat_cnt(lt_q);
            endcase
            total_q <= sat_cnt(total_q);
            last_q  <= code;
            run_q   <= run_d;
         end
         state_q <= state_d;
      end
   end

   assign bus.eq_count    = eq_q;
   assign bus.gt_count    = gt_q;
   assign bus.lt_count    = lt_q;
   assign bus.total_count = total_q;
   assign bus.last_result = last_q;
   assign bus.run_len     = run_q;
   assign bus.alert       = (state_q == ALERT);
   assign bus.err         = err_q;
   assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_comparator_stats_4_bit.sv
// Bench for comparator_stats_4_bit: three instances (default, narrow saturating, RUN_LIMIT=1)
// checked against a behavioural model through an expected-value queue.
module tb_comparator_stats_4_bit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   comparator_stats_4_bit_if #(.CNT_W(8), .RUN_W(4)) m_if ();
   comparator_stats_4_bit_if #(.CNT_W(3), .RUN_W(3)) s_if ();
   comparator_stats_4_bit_if #(.CNT_W(8), .RUN_W(4)) o_if ();

   comparator_stats_4_bit #(.CNT_W(8), .RUN_W(4), .RUN_LIMIT(4)) u_main (
      .clk(clk), .rst(rst), .bus(m_if.slave));
   comparator_stats_4_bit #(.CNT_W(3), .RUN_W(3), .RUN_LIMIT(4)) u_sat (
      .clk(clk), .rst(rst), .bus(s_if.slave));
   comparator_stats_4_bit #(.CNT_W(8), .RUN_W(4), .RUN_LIMIT(1)) u_one (
      .clk(clk), .rst(rst), .bus(o_if.slave));

   typedef struct {
      int eq; int gt; int lt; int tot; int last; int run; int alert; int err;
   } model_t;

   model_t mdl [3];
   int cmax [3] = '{255, 7, 255};
   int rmax [3] = '{15, 7, 15};
   int lim  [3] = '{4, 4, 1};

   logic [39:0] exp_q [$];
   logic [39:0] obs_v;
   logic [39:0] exp_v;
   logic [39:0] want;
   int checks = 0;
   int errors = 0;

   function automatic model_t model_next(model_t m, int sel, bit c, bit v, bit e, bit g, bit l);
      model_t n;
      int code;
      n = m;
      if (c) begin
         n = '{default: 0};
         return n;
      end
      if (!v) return n;
      if ((int'(e) + int'(g) + int'(l)) != 1) begin
         n.err = 1;
         return n;
      end
      code = e ? 1 : (g ? 2 : 3);
      if (code == 1) n.eq = (n.eq < cmax[sel]) ? n.eq + 1 : n.eq;
      if (code == 2) n.gt = (n.gt < cmax[sel]) ? n.gt + 1 : n.gt;
      if (code == 3) n.lt = (n.lt < cmax[sel]) ? n.lt + 1 : n.lt;
      n.tot = (n.tot < cmax[sel]) ? n.tot + 1 : n.tot;
      if (code == n.last) begin
         n.run = (n.run < rmax[sel]) ? n.run + 1 : n.run;
      end else begin
         n.run  = 1;
         n.last = code;
      end
      n.alert = (n.run >= lim[sel]) ? 1 : 0;
      return n;
   endfunction

   function automatic logic [39:0] pack_exp(model_t m);
      return {8'(m.eq), 8'(m.gt), 8'(m.lt), 8'(m.tot), 2'(m.last), 4'(m.run),
              1'(m.alert), 1'(m.err)};
   endfunction

   function automatic logic [39:0] obs_of(int sel);
      case (sel)
         1: return {5'd0, s_if.eq_count, 5'd0, s_if.gt_count, 5'd0, s_if.lt_count,
                    5'd0, s_if.total_count, s_if.last_result, 1'b0, s_if.run_len,
                    s_if.alert, s_if.err};
         2: return {o_if.eq_count, o_if.gt_count, o_if.lt_count, o_if.total_count,
                    o_if.last_result, o_if.run_len, o_if.alert, o_if.err};
         default: return {m_if.eq_count, m_if.gt_count, m_if.lt_count, m_if.total_count,
                          m_if.last_result, m_if.run_len, m_if.alert, m_if.err};
      endcase
   endfunction

   task automatic drive_idle();
      m_if.clear = 1'b0; m_if.in_valid = 1'b0;
      m_if.a_eq_b = 1'b0; m_if.a_gt_b = 1'b0; m_if.a_lt_b = 1'b0;
      s_if.clear = 1'b0; s_if.in_valid = 1'b0;
      s_if.a_eq_b = 1'b0; s_if.a_gt_b = 1'b0; s_if.a_lt_b = 1'b0;
      o_if.clear = 1'b0; o_if.in_valid = 1'b0;
      o_if.a_eq_b = 1'b0; o_if.a_gt_b = 1'b0; o_if.a_lt_b = 1'b0;
   endtask

   // Drive one cycle on one instance, push the model's expectation, wait past the edge.
   task automatic step(int sel, bit r, bit c, bit v, bit e, bit g, bit l);
      drive_idle();
      rst = r;
      case (sel)
         1: begin s_if.clear = c; s_if.in_valid = v;
                  s_if.a_eq_b = e; s_if.a_gt_b = g; s_if.a_lt_b = l; end
         2: begin o_if.clear = c; o_if.in_valid = v;
                  o_if.a_eq_b = e; o_if.a_gt_b = g; o_if.a_lt_b = l; end
         default: begin m_if.clear = c; m_if.in_valid = v;
                        m_if.a_eq_b = e; m_if.a_gt_b = g; m_if.a_lt_b = l; end
      endcase
      if (r) begin
         for (int k = 0; k < 3; k++) mdl[k] = '{default: 0};
      end else begin
         mdl[sel] = model_next(mdl[sel], sel, c, v, e, g, l);
      end
      exp_q.push_back(pack_exp(mdl[sel]));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 0, 0, 0, 0, 0);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
      want = 40'h0;
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL reset_zero got %h exp %h", obs_of(0), want);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL idle_hold[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_mixed();
      int a_v [4] = '{10, 11, 0, 15};
      int b_v [4] = '{10, 10, 15, 0};
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, a_v[i] == b_v[i], a_v[i] > b_v[i], a_v[i] < b_v[i]);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL mixed[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
      want = {8'd1, 8'd2, 8'd1, 8'd4, 2'b10, 4'd1, 1'b0, 1'b0};
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL mixed_final got %h exp %h", obs_of(0), want);
      end
   endtask

   task automatic test_alert();
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 1, 0, 0);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL alert_eq[%0d] got %h exp %h", i, obs_v, exp_v);
         end
         if (i == 2) begin
            checks++;
            if (m_if.alert !== 1'b0) begin
               errors++; $display("FAIL alert_early got %b exp 0", m_if.alert);
            end
         end
         if (i == 3) begin
            want = {8'd4, 8'd0, 8'd0, 8'd4, 2'b01, 4'd4, 1'b1, 1'b0};
            checks++;
            if (obs_of(0) !== want) begin
               errors++; $display("FAIL alert_rise got %h exp %h", obs_of(0), want);
            end
         end
      end
      step(0, 0, 0, 1, 0, 0, 1);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL alert_break got %h exp %h", obs_v, exp_v);
      end
      want = {8'd5, 8'd0, 8'd1, 8'd6, 2'b11, 4'd1, 1'b0, 1'b0};
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL alert_drop got %h exp %h", obs_of(0), want);
      end
   endtask

   task automatic test_run_sat();
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 1, 1, 0, 0);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL run_sat[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
      want = {8'd20, 8'd0, 8'd0, 8'd20, 2'b01, 4'd15, 1'b1, 1'b0};
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL run_sat_final got %h exp %h", obs_of(0), want);
      end
   endtask

   task automatic test_illegal();
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0, 1, 0);
         void'(exp_q.pop_front());
      end
      step(0, 0, 0, 1, 1, 1, 0);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL illegal_eq_gt got %h exp %h", obs_v, exp_v);
      end
      step(0, 0, 0, 1, 0, 0, 0);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL illegal_none got %h exp %h", obs_v, exp_v);
      end
      step(0, 0, 0, 1, 1, 1, 1);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL illegal_all got %h exp %h", obs_v, exp_v);
      end
      want = {8'd0, 8'd4, 8'd0, 8'd4, 2'b10, 4'd4, 1'b1, 1'b1};
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL illegal_hold got %h exp %h", obs_of(0), want);
      end
      step(0, 0, 1, 0, 0, 0, 0);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL illegal_clear got %h exp %h", obs_v, exp_v);
      end
      want = 40'h0;
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL illegal_clear_zero got %h exp %h", obs_of(0), want);
      end
   endtask

   task automatic test_saturation();
      step(1, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 1, 0, 1, 0);
         obs_v = obs_of(1); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL sat_gt[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
      want = {8'd0, 8'd7, 8'd0, 8'd7, 2'b10, 4'd7, 1'b1, 1'b0};
      checks++;
      if (obs_of(1) !== want) begin
         errors++; $display("FAIL sat_final got %h exp %h", obs_of(1), want);
      end
   endtask

   task automatic test_priority();
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0, 0, 1);
         void'(exp_q.pop_front());
      end
      checks++;
      if (m_if.alert !== 1'b1) begin
         errors++; $display("FAIL prio_setup got %b exp 1", m_if.alert);
      end
      step(0, 0, 1, 1, 0, 0, 1);
      obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
         errors++; $display("FAIL prio_clear got %h exp %h", obs_v, exp_v);
      end
      want = 40'h0;
      checks++;
      if (obs_of(0) !== want) begin
         errors++; $display("FAIL prio_zero got %h exp %h", obs_of(0), want);
      end
   endtask

   task automatic test_limit_one();
      bit seq_e [4] = '{1, 0, 0, 1};
      bit seq_g [4] = '{0, 1, 1, 1};
      bit seq_l [4] = '{0, 0, 0, 0};
      step(2, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         step(2, 0, 0, 1, seq_e[i], seq_g[i], seq_l[i]);
         obs_v = obs_of(2); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL limit_one[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
      want = {8'd1, 8'd2, 8'd0, 8'd3, 2'b10, 4'd2, 1'b1, 1'b1};
      checks++;
      if (obs_of(2) !== want) begin
         errors++; $display("FAIL limit_one_final got %h exp %h", obs_of(2), want);
      end
   endtask

   task automatic test_back_to_back();
      bit c, v, e, g, l;
      int code;
      int prev = 1;
      logic [2:0] f;
      step(0, 0, 1, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      for (int i = 0; i < 300; i++) begin
         c = ($urandom_range(0, 24) == 0);
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 8) begin
            code = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : prev;
            prev = code;
            f = (code == 1) ? 3'b100 : ((code == 2) ? 3'b010 : 3'b001);
         end else begin
            f = 3'($urandom_range(0, 7));
         end
         e = f[2]; g = f[1]; l = f[0];
         step(0, 0, c, v, e, g, l);
         obs_v = obs_of(0); exp_v = exp_q.pop_front(); checks++;
         if (obs_v !== exp_v) begin
            errors++; $display("FAIL random[%0d] got %h exp %h", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) mdl[k] = '{default: 0};
      drive_idle();
      test_reset();
      test_mixed();
      test_alert();
      test_run_sat();
      test_illegal();
      test_saturation();
      test_priority();
      test_limit_one();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
